// File: rtl/ras_link_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ras_pkg
// Brief    : Shared widths and entry types for the linked-list return stack.
// Revision : 1.0
// ============================================================================
package ras_pkg;

    localparam int RAS_ADDR  = 4;
    localparam int RAS_DEPTH = 1 << RAS_ADDR;
    localparam int RAS_XLEN  = 32;

    typedef logic [RAS_ADDR-1:0] slot_t;
    typedef logic [RAS_XLEN-1:0] ra_t;

    typedef struct packed {
        ra_t   ra;
        slot_t link;
    } ras_entry_t;

endpackage
`default_nettype wire

// File: rtl/ras_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ras_stack_if / ras_alloc_if
// Brief    : Client-side stack bus and allocator-side bus of ras_link_ctrl.
// Revision : 1.0
// ============================================================================
interface ras_stack_if #(
    parameter int ADDR = ras_pkg::RAS_ADDR,
    parameter int XLEN = ras_pkg::RAS_XLEN
);
    logic            push;
    logic [XLEN-1:0] push_data;
    logic            pop;
    logic            pop_valid;
    logic [XLEN-1:0] pop_data;
    logic            pop_underflow;
    logic [XLEN-1:0] peek_data;
    logic [ADDR:0]   count;
    logic            empty;
    logic            full;

    modport master (
        output push, push_data, pop,
        input  pop_valid, pop_data, pop_underflow, peek_data, count, empty, full
    );
    modport slave (
        input  push, push_data, pop,
        output pop_valid, pop_data, pop_underflow, peek_data, count, empty, full
    );
endinterface

interface ras_alloc_if #(
    parameter int ADDR = ras_pkg::RAS_ADDR
);
    logic [ADDR-1:0] alloc_addr;
    logic            alloc;
    logic            de_alloc;
    logic [ADDR-1:0] last_alloc_addr;
    logic            alloc_reset;
    logic [ADDR-1:0] reset_addr;

    modport master (
        input  alloc_addr,
        output alloc, de_alloc, last_alloc_addr, alloc_reset, reset_addr
    );
    modport slave (
        output alloc_addr,
        input  alloc, de_alloc, last_alloc_addr, alloc_reset, reset_addr
    );
endinterface
`default_nettype wire

// File: rtl/ras_entry_mem.sv
`default_nettype none
// ============================================================================
// Module   : ras_entry_mem
// Brief    : Unreset entry array, one clocked write port, one async read port.
// Revision : 1.0
// ============================================================================
module ras_entry_mem
    import ras_pkg::*;
#(
    parameter int  DEPTH   = RAS_DEPTH,
    parameter int  ADDR    = RAS_ADDR,
    parameter type entry_t = ras_entry_t
) (
    input  wire logic            clk,
    input  wire logic            we,
    input  wire logic [ADDR-1:0] waddr,
    input  entry_t               wdata,
    input  wire logic [ADDR-1:0] raddr,
    output entry_t               rdata
);

    entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/ras_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ras_link_ctrl
// Brief    : Linked-list return-address stack driving a slot allocator.
// Revision : 1.0
// ============================================================================
module ras_link_ctrl
    import ras_pkg::*;
#(
    parameter int ADDR         = RAS_ADDR,
    parameter int DEPTH        = RAS_DEPTH,
    parameter int XLEN         = RAS_XLEN,
    parameter int INITIAL_ADDR = 0
) (
    input  wire logic clk,
    input  wire logic reset,
    ras_stack_if.slave stk,
    ras_alloc_if.master alc
);

    typedef struct packed {
        logic [XLEN-1:0] ra;
        logic [ADDR-1:0] link;
    } entry_t;

    localparam logic [ADDR:0]   C_DEPTH = (ADDR+1)'(DEPTH);
    localparam logic [ADDR-1:0] C_INIT  = ADDR'(INITIAL_ADDR);

    logic [ADDR-1:0] r_top;
    logic [ADDR:0]   r_count;
    logic            r_pop_valid;
    logic [XLEN-1:0] r_pop_data;
    logic            r_pop_underflow;

    logic            w_empty;
    logic            w_full;
    logic            w_push_new;
    logic            w_replace;
    logic            w_pop_only;
    logic            w_we;
    logic [ADDR-1:0] w_waddr;
    entry_t          w_wdata;
    entry_t          w_rdata;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    // A pop on an empty stack never cancels the push: it allocates as usual.
    assign w_push_new = stk.push & (~stk.pop | w_empty);
    assign w_replace  = stk.push & stk.pop & ~w_empty;
    assign w_pop_only = stk.pop & ~stk.push & ~w_empty;

    assign w_we         = stk.push & ~reset;
    assign w_waddr      = w_replace ? r_top : alc.alloc_addr;
    assign w_wdata.ra   = stk.push_data;
    assign w_wdata.link = w_replace ? w_rdata.link : r_top;

    ras_entry_mem #(
        .DEPTH   (DEPTH),
        .ADDR    (ADDR),
        .entry_t (entry_t)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (r_top),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top           <= C_INIT;
            r_count         <= '0;
            r_pop_valid     <= 1'b0;
            r_pop_data      <= '0;
            r_pop_underflow <= 1'b0;
        end else begin
            r_pop_valid <= stk.pop;
            if (stk.pop) begin
                r_pop_data      <= w_empty ? '0 : w_rdata.ra;
                r_pop_underflow <= w_empty;
            end
            if (w_push_new) begin
                r_top <= alc.alloc_addr;
                if (!w_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop_only) begin
                r_top   <= w_rdata.link;
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign stk.pop_valid     = r_pop_valid;
    assign stk.pop_data      = r_pop_data;
    assign stk.pop_underflow = r_pop_underflow;
    assign stk.peek_data     = w_empty ? '0 : w_rdata.ra;
    assign stk.count         = r_count;
    assign stk.empty         = w_empty;
    assign stk.full          = w_full;

    assign alc.alloc           = w_push_new & ~reset;
    assign alc.de_alloc        = w_pop_only & ~reset;
    assign alc.last_alloc_addr = r_top;
    assign alc.alloc_reset     = reset;
    assign alc.reset_addr      = C_INIT;

endmodule
`default_nettype wire

// File: tb/tb_ras_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ras_link_ctrl
// Brief    : Scoreboard bench for ras_link_ctrl with a circular slot allocator.
// Revision : 1.0
// ============================================================================
module tb_ras_link_ctrl;

    typedef struct {
        logic [31:0] data;
        logic        uf;
    } exp_t;

    logic clk;
    logic reset;
    logic [3:0] alloc_ptr;
    exp_t exp_q [$];
    int   n_cmp;
    int   n_bad;

    ras_stack_if stk ();
    ras_alloc_if alc ();

    ras_link_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .stk   (stk),
        .alc   (alc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Allocator: hands out slots circularly, a freed slot is offered again next.
    always @(posedge clk) begin
        if (alc.alloc_reset)   alloc_ptr <= alc.reset_addr;
        else if (alc.alloc)    alloc_ptr <= alloc_ptr + 4'd1;
        else if (alc.de_alloc) alloc_ptr <= alc.last_alloc_addr;
    end
    assign alc.alloc_addr = alloc_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && stk.pop_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_spurious: got pop_valid=1 expected no pending pop at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", stk.pop_data, e.data);
                check("pop_underflow", {31'd0, stk.pop_underflow}, {31'd0, e.uf});
            end
        end
    end

    task automatic expect_pop(input logic [31:0] d, input logic uf);
        exp_t e;
        e.data = d;
        e.uf   = uf;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit p, input logic [31:0] d, input bit q,
                        input bit ea, input bit ed, input int slot);
        stk.push      = p;
        stk.push_data = d;
        stk.pop       = q;
        @(negedge clk);
        check("alloc", {31'd0, alc.alloc}, {31'd0, ea});
        check("de_alloc", {31'd0, alc.de_alloc}, {31'd0, ed});
        if (ed) check("last_alloc_addr", {28'd0, alc.last_alloc_addr}, slot);
        @(posedge clk);
        #1;
        stk.push = 1'b0;
        stk.pop  = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        stk.push = 1'b0;
        stk.push_data = '0;
        stk.pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", {27'd0, stk.count}, 0);
        check("rst_empty", {31'd0, stk.empty}, 1);
        check("rst_full", {31'd0, stk.full}, 0);
        check("rst_pop_valid", {31'd0, stk.pop_valid}, 0);
        check("rst_peek", stk.peek_data, 0);
        check("rst_alloc_reset", {31'd0, alc.alloc_reset}, 1);
        check("rst_reset_addr", {28'd0, alc.reset_addr}, 0);
        reset = 1'b0;

        // Three pushes then three pops in LIFO order
        step(1, 32'h100, 0, 1, 0, 0);
        step(1, 32'h200, 0, 1, 0, 0);
        step(1, 32'h300, 0, 1, 0, 0);
        check("count3", {27'd0, stk.count}, 3);
        check("peek3", stk.peek_data, 32'h300);
        expect_pop(32'h300, 0); step(0, 0, 1, 0, 1, 2);
        expect_pop(32'h200, 0); step(0, 0, 1, 0, 1, 1);
        expect_pop(32'h100, 0); step(0, 0, 1, 0, 1, 0);
        idle();
        check("empty_after_pops", {31'd0, stk.empty}, 1);

        // Underflow
        expect_pop(32'd0, 1); step(0, 0, 1, 0, 0, 0);
        idle();
        check("count_after_uf", {27'd0, stk.count}, 0);

        // Push then simultaneous push+pop replaces the top in place
        step(1, 32'h10, 0, 1, 0, 0);
        expect_pop(32'h10, 0); step(1, 32'h20, 1, 0, 0, 0);
        check("peek_replace", stk.peek_data, 32'h20);
        check("count_replace", {27'd0, stk.count}, 1);
        expect_pop(32'h20, 0); step(0, 0, 1, 0, 1, 0);

        // Overfill: 17 pushes into 16 slots drop the oldest entry
        for (int i = 1; i <= 17; i++) step(1, i, 0, 1, 0, 0);
        check("count_full", {27'd0, stk.count}, 16);
        check("full", {31'd0, stk.full}, 1);
        check("peek_full", stk.peek_data, 17);
        for (int k = 0; k < 16; k++) begin
            expect_pop(32'(17 - k), 0);
            step(0, 0, 1, 0, 1, (k == 0) ? 0 : 16 - k);
        end
        expect_pop(32'd0, 1); step(0, 0, 1, 0, 0, 0);
        idle();
        check("count_after_drain", {27'd0, stk.count}, 0);

        // Push, pop, push reuses the freed slot
        step(1, 32'hA, 0, 1, 0, 0);
        expect_pop(32'hA, 0); step(0, 0, 1, 0, 1, 1);
        step(1, 32'hB, 0, 1, 0, 0);
        check("peek_reuse", stk.peek_data, 32'hB);
        check("count_reuse", {27'd0, stk.count}, 1);
        expect_pop(32'hB, 0); step(0, 0, 1, 0, 1, 1);

        // Reset while a pop result is being presented with count=5
        for (int i = 0; i < 6; i++) step(1, 32'h1000 + i, 0, 1, 0, 0);
        expect_pop(32'h1005, 0); step(0, 0, 1, 0, 1, 6);
        check("pre_reset_count", {27'd0, stk.count}, 5);
        #1;
        reset = 1'b1;
        #1;
        check("async_count", {27'd0, stk.count}, 0);
        check("async_pop_valid", {31'd0, stk.pop_valid}, 0);
        check("async_alloc_reset", {31'd0, alc.alloc_reset}, 1);
        exp_q.delete();
        stk.push = 1'b1;
        stk.push_data = 32'h77;
        @(negedge clk);
        check("alloc_in_reset", {31'd0, alc.alloc}, 0);
        check("de_alloc_in_reset", {31'd0, alc.de_alloc}, 0);
        repeat (2) @(posedge clk);
        #1;
        stk.push = 1'b0;
        reset = 1'b0;
        step(1, 32'h55, 0, 1, 0, 0);
        check("peek_post_reset", stk.peek_data, 32'h55);
        check("count_post_reset", {27'd0, stk.count}, 1);
        expect_pop(32'h55, 0); step(0, 0, 1, 0, 1, 0);
        idle();
        idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ras_link_ctrl.md
Name: ras_link_ctrl

Overview:
Linked-list return-address-stack controller. It sits directly downstream of memory_allocator: it consumes `alloc_addr` and drives `alloc`, `de_alloc`, `last_alloc_addr` and the allocator's functional reset. Each push allocates one slot, stores the return address and a link to the previous top, and makes the new slot the top. Each pop returns the top entry, frees its slot and follows the link down.

Parameters:
ADDR, 4, slot pointer width (matches allocator ADDR)
DEPTH, 16, number of slots (2**ADDR)
XLEN, 32, return-address width
INITIAL_ADDR, 0, allocator start slot; value driven on `reset_addr`

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
push  in  1  push request (call)
push_data  in  XLEN  return address to push
pop  in  1  pop request (return)
pop_valid  out  1  registered: pop completed last cycle
pop_data  out  XLEN  registered popped address (0 on underflow)
pop_underflow  out  1  registered: last pop found stack empty
peek_data  out  XLEN  combinational ra_mem[top]; 0 when empty
count  out  ADDR+1  live entries, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
alloc_addr  in  ADDR  slot offered by allocator this cycle
alloc  out  1  consume alloc_addr
de_alloc  out  1  free slot on last_alloc_addr
last_alloc_addr  out  ADDR  slot being freed (= top)
alloc_reset  out  1  allocator functional reset
reset_addr  out  ADDR  constant INITIAL_ADDR

Behaviour:
- State: top (ADDR), count (ADDR+1), ra_mem[DEPTH] (XLEN), link_mem[DEPTH] (ADDR), pop_valid/pop_data/pop_underflow regs.
- Reset (async assert): top=INITIAL_ADDR, count=0, pop_valid=0, pop_data=0, pop_underflow=0. Memories are not reset.
- alloc_reset = reset. This holds the allocator at INITIAL_ADDR. Reset must be held ≥2 clk edges.
- alloc=0 and de_alloc=0 while reset is high.
- Memories use combinational read and write on the clock edge.
- Push only (push & !pop):
  - alloc=1.
  - ra_mem[alloc_addr]<=push_data.
  - link_mem[alloc_addr]<=top.
  - top<=alloc_addr.
  - count<=min(count+1,DEPTH).
- Full push: the allocator recycles circularly, so the slot reused is the oldest entry. count stays at DEPTH and the bottom entry is silently lost.
- Pop only (pop & !push), count>0:
  - de_alloc=1, last_alloc_addr=top.
  - pop_data<=ra_mem[top], top<=link_mem[top], count<=count-1.
  - pop_valid<=1, pop_underflow<=0.
- Pop only, count==0:
  - no allocator action, top unchanged.
  - pop_valid<=1, pop_underflow<=1, pop_data<=0.
- Push & pop same cycle, count>0:
  - replace top: ra_mem[top]<=push_data.
  - no alloc/de_alloc; count and top unchanged.
  - pop_valid<=1, pop_data<=old ra_mem[top].
- Push & pop same cycle, count==0: behaves as push only, plus pop_valid<=1, pop_underflow<=1, pop_data<=0.
- Idle cycles: pop_valid<=0. Other pop regs hold.
- last_alloc_addr is driven to top every cycle. It is only meaningful when de_alloc=1.
- Latency: pop result appears 1 cycle after pop. peek_data reflects a push on the next cycle.
- Back-to-back traffic:
  - push,push: the allocator presents the next slot next cycle, so no bubble.
  - pop then push: the allocator re-offers the freed slot, and the push reuses it.
  - pop,pop: the new top comes from link_mem; no bubble.
- Arithmetic: count is ADDR+1 bits, saturates at DEPTH and never wraps below 0. Slot pointers wrap mod DEPTH inside the allocator only.
- Reset mid-operation: all in-flight pop results are discarded (pop_valid=0 immediately).

Decomposition:
- ras_pkg:
  - ADDR, DEPTH and XLEN defaults.
  - typedef slot_t (logic [ADDR-1:0]) and ra_t (logic [XLEN-1:0]).
  - typedef ras_entry_t {ra_t ra; slot_t link;}.
- One sub-module, ras_entry_mem: DEPTH×ras_entry_t array with one write port and one combinational read port. The controller instantiates it with the top pointer as read address.

Test Plan:
- Reset then push 0x100, 0x200, 0x300 (allocator modelled or instantiated) -> count=3, peek=0x300, alloc pulsed 3 cycles on slots 0,1,2.
- Then pop ×3 -> pop_data 0x300, 0x200, 0x100 on consecutive cycles; de_alloc with last_alloc_addr 2,1,0; empty=1.
- Pop when empty -> next cycle pop_valid=1, pop_underflow=1, pop_data=0; count stays 0, de_alloc=0.
- Push 0x10, then push+pop same cycle with 0x20 -> pop_data=0x10, peek=0x20, count=1, no alloc/de_alloc that cycle.
- Push 17 values 1..17 with DEPTH=16 -> count=16, full=1. Popping 16 yields 17..2, then underflow.
- Push 0xA, pop, push 0xB -> the second push reuses the same slot as 0xA; peek=0xB, count=1.
- Assert reset mid-sequence with count=5 -> count=0 and pop_valid=0 asynchronously; alloc_reset high; first push after release uses slot INITIAL_ADDR.
